fp_add_sched: RTL and testbench
===============================

# fp_add_sched

Round-robin scheduler that shares one `fp_add` instance between `NUM_REQ` requesters. It accepts operand requests over valid/ready handshakes and drives the adder's start/operand ports. It captures the unrounded result bundle when the adder reports done, and returns that bundle to the owning requester over a per-requester valid/ready response channel. It sits between the issue logic of the FP lanes and the shared adder; rounding stays downstream of the response.

## Interface
Parameters:
- `FP_FORMAT`, default `FP32`: format passed through to the adder; `FP_WIDTH = fp_width(FP_FORMAT)`.
- `NUM_REQ`, default 2: number of requesters, 2..8; `ID_W = $clog2(NUM_REQ)`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  `NUM_REQ`  request pending, one bit per requester.
- `req_ready_o`  out  `NUM_REQ`  request accepted; one-hot or zero.
- `req_a_i`, `req_b_i`  in  `NUM_REQ`×`FP_WIDTH`  operands.
- `req_sub_i`  in  `NUM_REQ`  subtract select.
- `req_rnd_i`  in  `NUM_REQ`×`roundmode_e`  rounding mode.
- `rsp_valid_o`  out  `NUM_REQ`  result valid for the owner; one-hot or zero.
- `rsp_ready_i`  in  `NUM_REQ`  owner accepts the result.
- `rsp_res_o`  out  `uround_res_t`  captured result bundle, shared by all requesters.
- `rsp_id_o`  out  `ID_W`  owner index.
- `add_a_o`, `add_b_o`  out  `FP_WIDTH`  adder operands.
- `add_sub_o`  out  1  adder subtract select.
- `add_rnd_o`  out  `roundmode_e`  adder rounding mode.
- `add_start_o`  out  1  adder start.
- `add_done_i`  in  1  adder done.
- `add_res_i`  in  `uround_res_t`  adder result bundle.
- `busy_o`  out  1  state is not IDLE.
- `op_cnt_o`  out  32  count of completed response handshakes.

## Operation
States are IDLE, ISSUE and RESP.
- **IDLE**
  - The arbiter scans `req_valid_i`, starting at index `prio_q` and wrapping modulo `NUM_REQ`.
  - The first set bit `g` gets `req_ready_o[g]=1` combinationally in the same cycle.
  - On that handshake, `a`, `b`, `sub`, `rnd` and `g` are registered into `owner_q`.
  - `prio_q` is updated to `(g+1) mod NUM_REQ`, and the state moves to ISSUE.
  - With no valid request, the state stays IDLE and all `req_ready_o` are 0.
- **ISSUE**
  - `add_start_o=1`, and the `add_*_o` ports carry the registered operands.
  - When `add_done_i=1`, `add_res_i` is captured into `res_q` and the state moves to RESP.
  - Otherwise the state holds; `add_start_o` stays high and the operands stay stable.
- **RESP**
  - `rsp_valid_o[owner_q]=1`, `rsp_res_o=res_q`, `rsp_id_o=owner_q`.
  - On `rsp_ready_i[owner_q]`, `op_cnt_o` increments and the state moves to IDLE.
  - `rsp_ready_i` bits of non-owners are ignored.
- `req_ready_o` is all-zero in ISSUE and RESP; at most one request is outstanding.
- In IDLE, `add_start_o=0` and the `add_*_o` ports hold their last registered values.
- `op_cnt_o` wraps from 0xFFFFFFFF to 0.
- Arbitration uses only `prio_q`; requesters drop and raise `req_valid_i` freely while not granted.
- Reset (`rst_ni=0` at a clock edge) from any state:
  - state returns to IDLE; `prio_q`, `owner_q`, `res_q`, `op_cnt_o` and the operand registers clear to 0;
  - any in-flight operation is discarded with no response;
  - all outputs read 0 in the cycle after the reset edge.

## Timing
- Request handshake is in cycle T (IDLE); `add_start_o` is high from T+1.
- With the combinational adder (`add_done_i = add_start_o`), the result is captured at the end of T+1 and `rsp_valid_o` is high from T+2.
- If the response handshake happens at T+2, the next grant is possible at T+3: peak throughput is one operation per 3 cycles.
- Each adder stall cycle (`add_done_i=0`) adds one cycle; `rsp_ready_i` backpressure holds RESP indefinitely.
- `rsp_valid_o`, `rsp_res_o` and `rsp_id_o` are registered; `req_ready_o` is combinational from `req_valid_i` and state.

## Test plan
- **Single request:** FP32, req0 `a=0x3F800000`, `b=0x40000000`, `sub=0`, adder done tied to start.
  - Expect `rsp_valid_o=01` at T+2, `rsp_res_o.u_result=0x40400000`, `round_en=1`, `rs=0`, `rsp_id_o=0`, `op_cnt_o=1` after the handshake.
- **Round-robin:** both requesters hold valid continuously, responses accepted immediately.
  - Expect grants 0,1,0,1 at cycles 0,3,6,9.
  - Expect each response's result to match that requester's operands.
- **Backpressure:** hold `rsp_ready_i[owner]=0` for 5 cycles.
  - Expect `rsp_valid_o` and `rsp_res_o` stable, `req_ready_o=0`.
  - Expect a non-owner `rsp_ready_i=1` to have no effect.
- **Adder stall:** `add_done_i` low for 4 cycles after start.
  - Expect `add_start_o` and operands stable throughout; the response appears 1 cycle after done.
- **Reset mid-operation:** assert `rst_ni=0` during ISSUE with `op_cnt_o=7`.
  - Expect next cycle: IDLE, `op_cnt_o=0`, no response for the dropped request, first grant afterwards to req0.
- **Counter wrap:** preload via 2^32 ops (or force `op_cnt_o` to 0xFFFFFFFF), complete one op.
  - Expect `op_cnt_o=0`.

Source files
------------

// File: rtl/fp_add_sched.sv
// fp_add_sched_pkg + fp_add_sched
//
// Shares one floating-point adder between NUM_REQ requesters. Requests are
// arbitrated round-robin. The winning operands are registered and held on
// the adder port until the adder reports done. The unrounded result bundle
// is then captured and returned to the requester that issued it. Rounding
// happens downstream of the response channel, so the bundle carries the
// rounding mode with it.
//
// Handshake rule, used by every channel in this block: a transfer happens
// on a rising clk_i edge where valid and ready are both 1. A producer may
// raise or drop valid freely until that edge. The consumer's ready may
// depend combinationally on valid. Nothing is transferred in a cycle where
// either one is 0.
//
// Ports (fp_add_sched):
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_valid_i/ready_o      per-requester request handshake (ready one-hot or 0)
//   req_a_i, req_b_i         per-requester operands
//   req_sub_i, req_rnd_i     per-requester subtract select and rounding mode
//   rsp_valid_o/ready_i      per-requester response handshake (valid one-hot or 0)
//   rsp_res_o, rsp_id_o      captured result bundle and its owner index
//   add_a_o, add_b_o         operands to the shared adder
//   add_sub_o, add_rnd_o     subtract select and rounding mode to the adder
//   add_start_o, add_done_i  adder start / done
//   add_res_i                adder result bundle
//   busy_o                   scheduler is not idle
//   op_cnt_o                 completed response handshakes (wraps at 2^32)
//   state_o                  current FSM state, for observation

package fp_add_sched_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    BF16 = 2'd1,
    FP32 = 2'd2,
    FP64 = 2'd3
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  // Wide enough for the largest format; narrower results are zero-extended.
  localparam int RES_W = 64;

  // Adder output before rounding: the raw result word, the rounding mode it
  // must be rounded with, a flag saying rounding is needed, and the
  // round/sticky bits.
  typedef struct packed {
    logic [RES_W-1:0] u_result;
    roundmode_e       rnd;
    logic             round_en;
    logic [1:0]       rs;
  } uround_res_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic int fp_width(input fp_format_e fmt);
    case (fmt)
      FP16:    return 16;
      BF16:    return 16;
      FP32:    return 32;
      default: return 64;
    endcase
  endfunction

endpackage

module fp_add_sched
  import fp_add_sched_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  parameter int         NUM_REQ   = 2,
  localparam int        FP_WIDTH  = fp_width(FP_FORMAT),
  localparam int        ID_W      = $clog2(NUM_REQ)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic       [NUM_REQ-1:0]               req_valid_i,
  output logic       [NUM_REQ-1:0]               req_ready_o,
  input  logic       [NUM_REQ-1:0][FP_WIDTH-1:0] req_a_i,
  input  logic       [NUM_REQ-1:0][FP_WIDTH-1:0] req_b_i,
  input  logic       [NUM_REQ-1:0]               req_sub_i,
  input  roundmode_e [NUM_REQ-1:0]               req_rnd_i,
  output logic       [NUM_REQ-1:0]               rsp_valid_o,
  input  logic       [NUM_REQ-1:0]               rsp_ready_i,
  output uround_res_t                      rsp_res_o,
  output logic       [ID_W-1:0]            rsp_id_o,
  output logic       [FP_WIDTH-1:0]        add_a_o,
  output logic       [FP_WIDTH-1:0]        add_b_o,
  output logic                             add_sub_o,
  output roundmode_e                       add_rnd_o,
  output logic                             add_start_o,
  input  logic                             add_done_i,
  input  uround_res_t                      add_res_i,
  output logic                             busy_o,
  output logic       [31:0]                op_cnt_o,
  output state_e                           state_o
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     prio_q;
  logic [ID_W-1:0]     owner_q;
  logic [FP_WIDTH-1:0] a_q, b_q;
  logic                sub_q;
  roundmode_e          rnd_q;
  uround_res_t         res_q;
  logic [31:0]         op_cnt_q;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     prio_nxt;
  logic                req_hs;
  logic                rsp_hs;
  logic                res_cap;

  // Round-robin scan starting at prio_q. The modulo keeps the scan inside
  // 0..NUM_REQ-1 when NUM_REQ is not a power of two.
  always_comb begin
    int              idx_int;
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_int     = 0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_int = (int'(prio_q) + i) % NUM_REQ;
      idx     = idx_int[ID_W-1:0];
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign prio_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // A request cycle that coincides with reset is overridden by the reset.
  // Gating ready with reset keeps the requester from seeing a phantom accept.
  assign req_hs  = rst_ni && (state_q == ST_IDLE) && grant_found;
  assign rsp_hs  = (state_q == ST_RESP) && rsp_ready_i[owner_q];
  assign res_cap = (state_q == ST_ISSUE) && add_done_i;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_hs)  state_d = ST_ISSUE;
      ST_ISSUE: if (res_cap) state_d = ST_RESP;
      ST_RESP:  if (rsp_hs)  state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      prio_q   <= '0;
      owner_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      rnd_q    <= RNE;
      res_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        prio_q  <= prio_nxt;
        owner_q <= grant_idx;
        a_q     <= req_a_i[grant_idx];
        b_q     <= req_b_i[grant_idx];
        sub_q   <= req_sub_i[grant_idx];
        rnd_q   <= req_rnd_i[grant_idx];
      end
      if (res_cap) begin
        res_q <= add_res_i;
      end
      if (rsp_hs) begin
        op_cnt_q <= op_cnt_q + 32'd1;
      end
    end
  end

  // The operand registers drive the adder in every state. Only start is
  // qualified by the state.
  assign add_a_o     = a_q;
  assign add_b_o     = b_q;
  assign add_sub_o   = sub_q;
  assign add_rnd_o   = rnd_q;
  assign add_start_o = (state_q == ST_ISSUE);

  assign req_ready_o = req_hs ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid_o = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign rsp_res_o   = res_q;
  assign rsp_id_o    = owner_q;

  assign busy_o   = (state_q != ST_IDLE);
  assign op_cnt_o = op_cnt_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: two FP32 requesters, directed vectors with
// hand-computed sums. The bench plays the shared adder. It looks up the
// operand pair in the vector table and echoes the rounding mode into the
// result bundle. Stimulus pushes the expected response on each grant. A
// monitor pops the queue on every response handshake and compares.
module tb_fp_add_sched;
  import fp_add_sched_pkg::*;

  localparam int NV = 8;
  //                                 1+2        2+2        1.5+0.5    3-1
  //                                 5+1        1-0.5      10+6       4-2
  localparam logic [31:0] VEC_A   [NV] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40400000,
                                           32'h40A00000, 32'h3F800000, 32'h41200000, 32'h40800000};
  localparam logic [31:0] VEC_B   [NV] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F800000,
                                           32'h3F800000, 32'h3F000000, 32'h40C00000, 32'h40000000};
  localparam logic        VEC_SUB [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] VEC_RES [NV] = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h40000000,
                                           32'h40C00000, 32'h3F000000, 32'h41800000, 32'h40000000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       [1:0]       req_valid_i = '0;
  logic       [1:0]       req_ready_o;
  logic       [1:0][31:0] req_a_i = '0;
  logic       [1:0][31:0] req_b_i = '0;
  logic       [1:0]       req_sub_i = '0;
  roundmode_e [1:0]       req_rnd_i = {RNE, RNE};
  logic       [1:0]       rsp_valid_o;
  logic       [1:0]       rsp_ready_i = '0;
  uround_res_t            rsp_res_o;
  logic       [0:0]       rsp_id_o;
  logic       [31:0]      add_a_o, add_b_o;
  logic                   add_sub_o;
  roundmode_e             add_rnd_o;
  logic                   add_start_o;
  logic                   add_done_i;
  uround_res_t            add_res_i;
  logic                   busy_o;
  logic       [31:0]      op_cnt_o;
  state_e                 state_o;

  logic manual = 1'b0;
  logic done_manual = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;
  logic [37:0] exp_q[$];  // {id[2:0], rnd[2:0], result[31:0]}

  fp_add_sched #(.FP_FORMAT(FP32), .NUM_REQ(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_sub_i(req_sub_i), .req_rnd_i(req_rnd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_id_o(rsp_id_o),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_sub_o(add_sub_o), .add_rnd_o(add_rnd_o),
    .add_start_o(add_start_o), .add_done_i(add_done_i), .add_res_i(add_res_i),
    .busy_o(busy_o), .op_cnt_o(op_cnt_o), .state_o(state_o)
  );

  // ---------------- adder model ----------------
  assign add_done_i = manual ? done_manual : add_start_o;

  always_comb begin
    add_res_i          = '0;
    add_res_i.u_result = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < NV; i++) begin
      if (add_a_o == VEC_A[i] && add_b_o == VEC_B[i] && add_sub_o == VEC_SUB[i])
        add_res_i.u_result = {32'h0, VEC_RES[i]};
    end
    add_res_i.rnd      = add_rnd_o;
    add_res_i.round_en = 1'b1;
    add_res_i.rs       = 2'b00;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int v, input int rnd);
    req_a_i[r]   = VEC_A[v];
    req_b_i[r]   = VEC_B[v];
    req_sub_i[r] = VEC_SUB[v];
    req_rnd_i[r] = roundmode_e'(rnd);
  endtask

  task automatic push_exp(input int r, input int v, input int rnd);
    exp_q.push_back({3'(r), 3'(rnd), VEC_RES[v]});
  endtask

  // One request from requester r: stall = adder cycles with done low,
  // bp = response cycles held off while the other requester pokes ready.
  task automatic single_op(input int r, input int v, input int rnd, input int stall, input int bp);
    int other;
    other = 1 - r;
    tick();
    set_req(r, v, rnd);
    req_valid_i = 2'(1 << r);
    rsp_ready_i = '0;
    manual      = (stall > 0);
    done_manual = 1'b0;
    at_neg();
    check("op_grant", 64'(req_ready_o), 64'(1 << r));
    push_exp(r, v, rnd);
    tick();
    req_valid_i = '0;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) done_manual = 1'b1;
      at_neg();
      check("op_start", 64'(add_start_o), 64'(1));
      check("op_a", 64'(add_a_o), 64'(VEC_A[v]));
      check("op_b", 64'(add_b_o), 64'(VEC_B[v]));
      check("op_sub", 64'(add_sub_o), 64'(VEC_SUB[v]));
      check("op_rnd", 64'(add_rnd_o), 64'(rnd));
      check("op_no_rsp", 64'(rsp_valid_o), 64'(0));
      tick();
    end
    manual      = 1'b0;
    done_manual = 1'b0;
    for (int k = 0; k < bp; k++) begin
      req_valid_i = 2'(1 << other);
      rsp_ready_i = 2'(1 << other);
      at_neg();
      check("bp_valid", 64'(rsp_valid_o), 64'(1 << r));
      check("bp_res", rsp_res_o.u_result, {32'h0, VEC_RES[v]});
      check("bp_no_grant", 64'(req_ready_o), 64'(0));
      check("bp_cnt", 64'(op_cnt_o), 64'(exp_cnt));
      tick();
    end
    req_valid_i = '0;
    rsp_ready_i = 2'(1 << r);
    at_neg();
    check("op_rsp_valid", 64'(rsp_valid_o), 64'(1 << r));
    check("op_rsp_id", 64'(rsp_id_o), 64'(r));
    check("op_rsp_res", rsp_res_o.u_result, {32'h0, VEC_RES[v]});
    check("op_busy", 64'(busy_o), 64'(1));
    tick();
    rsp_ready_i = '0;
    exp_cnt     = exp_cnt + 32'd1;
    at_neg();
    check("op_cnt", 64'(op_cnt_o), 64'(exp_cnt));
    check("op_idle", 64'(busy_o), 64'(0));
    check("op_rsp_clear", 64'(rsp_valid_o), 64'(0));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid_o != '0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", 64'(rsp_valid_o), 64'(0));
        end else if ((rsp_valid_o & rsp_ready_i) != '0) begin
          e = exp_q.pop_front();
          check("sb_valid", 64'(rsp_valid_o), 64'(1) << e[37:35]);
          check("sb_id", 64'(rsp_id_o), 64'(e[37:35]));
          check("sb_result", rsp_res_o.u_result, {32'h0, e[31:0]});
          check("sb_rnd", 64'(rsp_res_o.rnd), 64'(e[34:32]));
          check("sb_round_en", 64'(rsp_res_o.round_en), 64'(1));
          check("sb_rs", 64'(rsp_res_o.rs), 64'(0));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int vr[2];
    int rr[2];
    int g;
    logic gnt;

    // Reset with requests pending: nothing may be accepted.
    rst_n       = 1'b0;
    req_valid_i = 2'b11;
    tick();
    tick();
    at_neg();
    check("rst_ready", 64'(req_ready_o), 64'(0));
    check("rst_state", 64'(state_o), 64'(ST_IDLE));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_cnt", 64'(op_cnt_o), 64'(0));
    check("rst_start", 64'(add_start_o), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_rsp_res", 64'(rsp_res_o), 64'(0));
    tick();
    rst_n       = 1'b1;
    req_valid_i = '0;
    exp_cnt     = '0;

    // Single request, combinational adder: 1.0 + 2.0 = 3.0.
    single_op(0, 0, 0, 0, 0);
    // Adder stall of 4 cycles on requester 1: 2.0 + 2.0 = 4.0.
    single_op(1, 1, 1, 4, 0);

    // Round-robin: both requesters always valid, responses taken at once.
    vr = '{3, 4};
    rr = '{2, 4};
    tick();
    set_req(0, vr[0], rr[0]);
    set_req(1, vr[1], rr[1]);
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b11;
    for (int k = 0; k < 12; k++) begin
      at_neg();
      gnt = (k % 3 == 0);
      g   = (k / 3) % 2;
      check("rr_grant", 64'(req_ready_o), gnt ? 64'(1 << g) : 64'(0));
      if (gnt) begin
        push_exp(g, vr[g], rr[g]);
        vr[g] += 2;
      end
      tick();
      if (gnt) set_req(g, vr[g], rr[g]);
    end
    req_valid_i = '0;
    rsp_ready_i = '0;
    exp_cnt     = exp_cnt + 32'd4;
    at_neg();
    check("rr_cnt", 64'(op_cnt_o), 64'(exp_cnt));
    check("rr_idle", 64'(busy_o), 64'(0));

    // Backpressure for 5 cycles on requester 0: 1.5 + 0.5 = 2.0.
    single_op(0, 2, 3, 0, 5);

    // Reset during ISSUE with 7 ops done; the dropped op must never respond.
    tick();
    set_req(0, 7, 3);
    req_valid_i = 2'b01;
    manual      = 1'b1;
    done_manual = 1'b0;
    at_neg();
    check("rm_grant", 64'(req_ready_o), 64'(1));
    tick();
    req_valid_i = '0;
    at_neg();
    check("rm_in_issue", 64'(add_start_o), 64'(1));
    check("rm_cnt_before", 64'(op_cnt_o), 64'(7));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    manual  = 1'b0;
    exp_cnt = '0;
    at_neg();
    check("rm_state", 64'(state_o), 64'(ST_IDLE));
    check("rm_cnt", 64'(op_cnt_o), 64'(0));
    check("rm_start", 64'(add_start_o), 64'(0));
    check("rm_add_a", 64'(add_a_o), 64'(0));
    check("rm_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rm_rsp_id", 64'(rsp_id_o), 64'(0));
    check("rm_rsp_res", 64'(rsp_res_o), 64'(0));
    tick();
    at_neg();
    check("rm_no_rsp", 64'(rsp_valid_o), 64'(0));
    tick();
    set_req(0, 1, 0);
    set_req(1, 6, 1);
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b11;
    at_neg();
    check("rm_first_grant", 64'(req_ready_o), 64'(1));
    push_exp(0, 1, 0);
    tick();
    req_valid_i = '0;
    at_neg();
    tick();
    at_neg();
    tick();
    rsp_ready_i = '0;
    exp_cnt     = 32'd1;
    at_neg();
    check("rm_cnt_after", 64'(op_cnt_o), 64'(exp_cnt));

    // Counter wrap: preload 0xFFFFFFFF, complete one op (10 + 6 = 16).
    tick();
    force dut.op_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    at_neg();
    check("wrap_preload", 64'(op_cnt_o), 64'(32'hFFFF_FFFF));
    single_op(1, 6, 3, 0, 0);
    check("wrap_zero", 64'(op_cnt_o), 64'(0));

    repeat (3) tick();
    at_neg();
    check("sb_drain", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
